// File: rtl/vga_timing_pkg.sv
// Default VGA 640x480@60 timing constants and sync polarity encodings,
// shared by the sync generator and the renderer.
package vga_timing_pkg;

    localparam int DEF_H_DISPLAY = 640;
    localparam int DEF_H_FRONT   = 16;
    localparam int DEF_H_SYNC    = 96;
    localparam int DEF_H_BACK    = 48;
    localparam int DEF_V_DISPLAY = 480;
    localparam int DEF_V_FRONT   = 10;
    localparam int DEF_V_SYNC    = 2;
    localparam int DEF_V_BACK    = 33;

    localparam int DEF_H_TOTAL  = DEF_H_DISPLAY + DEF_H_FRONT + DEF_H_SYNC + DEF_H_BACK;
    localparam int DEF_V_TOTAL  = DEF_V_DISPLAY + DEF_V_FRONT + DEF_V_SYNC + DEF_V_BACK;
    localparam int DEF_HS_START = DEF_H_DISPLAY + DEF_H_FRONT;
    localparam int DEF_HS_END   = DEF_HS_START + DEF_H_SYNC;
    localparam int DEF_VS_START = DEF_V_DISPLAY + DEF_V_FRONT;
    localparam int DEF_VS_END   = DEF_VS_START + DEF_V_SYNC;

    localparam logic SYNC_ACTIVE_LOW  = 1'b0;
    localparam logic SYNC_ACTIVE_HIGH = 1'b1;

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: position counter with wrap flag, plus sync and active
// flags registered from the next count so they line up with the count.
module vga_axis_counter
    import vga_timing_pkg::*;
#(
    parameter int   DISPLAY = DEF_H_DISPLAY,
    parameter int   FRONT   = DEF_H_FRONT,
    parameter int   SYNC    = DEF_H_SYNC,
    parameter int   BACK    = DEF_H_BACK,
    parameter logic POL     = SYNC_ACTIVE_LOW,
    parameter int   W       = 10
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         adv,
    output logic [W-1:0] count,
    output logic         wrap,
    output logic         sync,
    output logic         active
);

    localparam int           TOTAL   = DISPLAY + FRONT + SYNC + BACK;
    localparam logic [W-1:0] LAST    = W'(TOTAL - 1);
    localparam logic [W-1:0] S_START = W'(DISPLAY + FRONT);
    localparam logic [W-1:0] S_END   = W'(DISPLAY + FRONT + SYNC);
    localparam logic [W-1:0] DISP    = W'(DISPLAY);
    localparam logic [W-1:0] ZERO    = W'(0);
    localparam logic [W-1:0] ONE     = W'(1);

    logic [W-1:0] count_r;
    logic [W-1:0] count_nxt_s;
    logic         sync_r;
    logic         active_r;

    // next position: hold unless advancing, wrap after the last position
    always_comb begin
        count_nxt_s = count_r;
        if (adv) begin
            if (count_r == LAST) begin
                count_nxt_s = ZERO;
            end else begin
                count_nxt_s = count_r + ONE;
            end
        end else begin
            count_nxt_s = count_r;
        end
    end

    // count and flags; flags derive from the next count so they never lag
    always_ff @(posedge clk) begin
        if (reset) begin
            count_r  <= ZERO;
            sync_r   <= ~POL;
            active_r <= 1'b1;
        end else begin
            count_r  <= count_nxt_s;
            sync_r   <= ((count_nxt_s >= S_START) && (count_nxt_s < S_END)) ? POL : ~POL;
            active_r <= (count_nxt_s < DISP);
        end
    end

    assign count  = count_r;
    assign wrap   = (count_r == LAST);
    assign sync   = sync_r;
    assign active = active_r;

endmodule

// File: rtl/vga_sync_gen.sv
// VGA raster timing generator: sync, display enable, pixel coordinates,
// line/frame/vblank strobes and a frame counter, advancing on pix_ce.
module vga_sync_gen
    import vga_timing_pkg::*;
#(
    parameter int   H_DISPLAY  = DEF_H_DISPLAY,
    parameter int   H_FRONT    = DEF_H_FRONT,
    parameter int   H_SYNC     = DEF_H_SYNC,
    parameter int   H_BACK     = DEF_H_BACK,
    parameter int   V_DISPLAY  = DEF_V_DISPLAY,
    parameter int   V_FRONT    = DEF_V_FRONT,
    parameter int   V_SYNC     = DEF_V_SYNC,
    parameter int   V_BACK     = DEF_V_BACK,
    parameter logic H_SYNC_POL = SYNC_ACTIVE_LOW,
    parameter logic V_SYNC_POL = SYNC_ACTIVE_LOW
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       pix_ce,
    output logic       hsync,
    output logic       vsync,
    output logic       display_on,
    output logic [9:0] hpos,
    output logic [9:0] vpos,
    output logic       line_start,
    output logic       frame_start,
    output logic       vblank_start,
    output logic [7:0] frame_count
);

    localparam logic [9:0] V_LAST_VISIBLE = 10'(V_DISPLAY - 1);

    logic       h_wrap_s;
    logic       v_wrap_s;
    logic       v_adv_s;
    logic       h_active_s;
    logic       v_active_s;
    logic       line_start_r;
    logic       frame_start_r;
    logic       vblank_start_r;
    logic [7:0] frame_count_r;

    assign v_adv_s = pix_ce & h_wrap_s;

    vga_axis_counter #(
        .DISPLAY (H_DISPLAY),
        .FRONT   (H_FRONT),
        .SYNC    (H_SYNC),
        .BACK    (H_BACK),
        .POL     (H_SYNC_POL),
        .W       (10)
    ) u_h_axis (
        .clk    (clk),
        .reset  (reset),
        .adv    (pix_ce),
        .count  (hpos),
        .wrap   (h_wrap_s),
        .sync   (hsync),
        .active (h_active_s)
    );

    vga_axis_counter #(
        .DISPLAY (V_DISPLAY),
        .FRONT   (V_FRONT),
        .SYNC    (V_SYNC),
        .BACK    (V_BACK),
        .POL     (V_SYNC_POL),
        .W       (10)
    ) u_v_axis (
        .clk    (clk),
        .reset  (reset),
        .adv    (v_adv_s),
        .count  (vpos),
        .wrap   (v_wrap_s),
        .sync   (vsync),
        .active (v_active_s)
    );

    // strobes describe the position being entered; they hold while pix_ce is low
    always_ff @(posedge clk) begin
        if (reset) begin
            line_start_r   <= 1'b0;
            frame_start_r  <= 1'b0;
            vblank_start_r <= 1'b0;
            frame_count_r  <= 8'd0;
        end else if (pix_ce) begin
            line_start_r   <= h_wrap_s;
            frame_start_r  <= h_wrap_s & v_wrap_s;
            vblank_start_r <= h_wrap_s & (vpos == V_LAST_VISIBLE);
            if (h_wrap_s & v_wrap_s) begin
                frame_count_r <= frame_count_r + 8'd1;
            end
        end
    end

    // both axis flags are registers updated on the same edge, so this is glitch-free
    assign display_on   = h_active_s & v_active_s;
    assign line_start   = line_start_r;
    assign frame_start  = frame_start_r;
    assign vblank_start = vblank_start_r;
    assign frame_count  = frame_count_r;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Self-checking bench for vga_sync_gen using a reduced raster (12x8 totals)
// and a model that derives every output from the number of pixel advances.
module tb_vga_sync_gen;

    localparam int HD = 6, HF = 2, HS = 2, HB = 2;
    localparam int VD = 4, VF = 1, VS = 2, VB = 1;
    localparam int HT = HD + HF + HS + HB;
    localparam int VT = VD + VF + VS + VB;
    localparam int FRAME = HT * VT;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       pix_ce = 1'b0;
    logic       hsync, vsync, display_on;
    logic [9:0] hpos, vpos;
    logic       line_start, frame_start, vblank_start;
    logic [7:0] frame_count;

    int  n_checks = 0;
    int  n_fail = 0;
    int  adv_n = 0;
    bit  check_en = 1'b0;

    vga_sync_gen #(
        .H_DISPLAY(HD), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
        .V_DISPLAY(VD), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
        .H_SYNC_POL(1'b0), .V_SYNC_POL(1'b0)
    ) dut (
        .clk(clk), .reset(reset), .pix_ce(pix_ce),
        .hsync(hsync), .vsync(vsync), .display_on(display_on),
        .hpos(hpos), .vpos(vpos),
        .line_start(line_start), .frame_start(frame_start),
        .vblank_start(vblank_start), .frame_count(frame_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (advances=%0d, t=%0t)", name, act, exp, adv_n, $time);
        end
    endtask

    // model state: pixel advances since the last reset
    always @(posedge clk) begin
        if (reset) adv_n <= 0;
        else if (pix_ce) adv_n <= adv_n + 1;
    end

    // per-cycle comparison of every output against the advance-count model
    always @(negedge clk) begin
        if (check_en) begin
            int h, v, fc;
            logic ehs, evs, edisp, els, efs, evb;
            h   = adv_n % HT;
            v   = (adv_n / HT) % VT;
            fc  = (adv_n / FRAME) % 256;
            ehs = (h >= HD + HF && h < HD + HF + HS) ? 1'b0 : 1'b1;
            evs = (v >= VD + VF && v < VD + VF + VS) ? 1'b0 : 1'b1;
            edisp = (h < HD) && (v < VD);
            els = (adv_n > 0) && (h == 0);
            efs = (adv_n > 0) && (adv_n % FRAME == 0);
            evb = (adv_n > 0) && (h == 0) && (v == VD);
            check("outputs",
                  {hsync, vsync, display_on, line_start, frame_start, vblank_start,
                   hpos, vpos, frame_count},
                  {ehs, evs, edisp, els, efs, evb, 10'(h), 10'(v), 8'(fc)});
        end
    end

    task automatic tick(input logic ce, input logic rst);
        pix_ce = ce;
        reset  = rst;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int hs_low, vs_low, disp, ls, fs, vb, cnt;
        bit found;

        @(posedge clk);
        #1;
        check_en = 1'b1;
        check("reset_hpos", hpos, 0);
        check("reset_vpos", vpos, 0);
        check("reset_syncs", {hsync, vsync}, 2'b11);
        check("reset_display_on", display_on, 1);
        check("reset_strobes", {line_start, frame_start, vblank_start}, 3'b000);
        check("reset_frame_count", frame_count, 0);

        // one full frame at full rate, tallying per-frame totals
        hs_low = 0; vs_low = 0; disp = 0; ls = 0; fs = 0; vb = 0;
        for (int i = 0; i < FRAME; i++) begin
            tick(1'b1, 1'b0);
            hs_low += (hsync == 1'b0);
            vs_low += (vsync == 1'b0);
            disp   += display_on;
            ls     += line_start;
            fs     += frame_start;
            vb     += vblank_start;
        end
        check("hsync_low_per_frame", hs_low, 16);
        check("vsync_low_per_frame", vs_low, 24);
        check("display_per_frame", disp, 24);
        check("line_starts_per_frame", ls, 8);
        check("frame_starts_per_frame", fs, 1);
        check("vblank_starts_per_frame", vb, 1);
        check("frame1_position", {hpos, vpos, frame_count}, {10'd0, 10'd0, 8'd1});

        // stall holds frame_start, then half rate covers one line in 2*HT clocks
        tick(1'b0, 1'b0);
        check("frame_start_held", frame_start, 1);
        for (int i = 0; i < HT; i++) begin
            tick(1'b1, 1'b0);
            tick(1'b0, 1'b0);
        end
        check("half_rate_line", {hpos, vpos, line_start}, {10'd0, 10'd1, 1'b1});

        // random pix_ce with occasional reset
        for (int i = 0; i < 2000; i++) begin
            tick(($urandom_range(0, 3) != 0), ($urandom_range(0, 199) == 0));
        end

        // reset from inside both sync windows, with pix_ce high
        found = 1'b0;
        for (int i = 0; i < 4 * FRAME && !found; i++) begin
            if (hpos == 10'd9 && vpos == 10'd6) found = 1'b1;
            else tick(1'b1, 1'b0);
        end
        check("reach_sync_window", found, 1);
        check("inside_sync_windows", {hsync, vsync}, 2'b00);
        tick(1'b1, 1'b1);
        check("midsync_reset_pos", {hpos, vpos, frame_count}, {10'd0, 10'd0, 8'd0});
        check("midsync_reset_syncs", {hsync, vsync, display_on}, 3'b111);
        check("midsync_reset_strobes", {line_start, frame_start, vblank_start}, 3'b000);
        cnt = 0;
        do begin
            tick(1'b1, 1'b0);
            cnt++;
        end while (frame_start !== 1'b1 && cnt < 4 * FRAME);
        check("first_frame_start_delay", cnt, FRAME);

        // frame counter wrap
        repeat (254 * FRAME) tick(1'b1, 1'b0);
        check("frame_count_255", frame_count, 255);
        repeat (FRAME) tick(1'b1, 1'b0);
        check("frame_count_wrap", {frame_count, hpos, vpos, frame_start}, {8'd0, 10'd0, 10'd0, 1'b1});

        @(negedge clk);
        check_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
